// File: rtl/ex_mem_flags_stage_if.sv
// EX/MEM boundary bundle: execute-stage inputs, stage controls and memory-stage outputs.
// The producer side (pipeline/hazard logic) is master; the stage register is slave.
interface ex_mem_flags_stage_if #(parameter int N = 64);
  logic         stall;
  logic         flush;
  logic         valid_E;
  logic         Branch_E;
  logic         bCondCheck_E;
  logic         setFlags_E;
  logic         MemRead_E;
  logic         MemWrite_E;
  logic         RegWrite_E;
  logic         MemtoReg_E;
  logic         zero_E;
  logic         negative_E;
  logic         overflow_E;
  logic         carry_E;
  logic [N-1:0] aluResult_E;
  logic [N-1:0] writeData_E;
  logic [4:0]   Rd_E;

  logic         valid_M;
  logic         Branch_M;
  logic         bCondCheck_M;
  logic         MemRead_M;
  logic         MemWrite_M;
  logic         RegWrite_M;
  logic         MemtoReg_M;
  logic         zero_M;
  logic         zero_flag;
  logic         negative;
  logic         overflow;
  logic         carry;
  logic [N-1:0] aluResult_M;
  logic [N-1:0] writeData_M;
  logic [4:0]   Rt_B_cond;
  logic [3:0]   nzcv_q;

  modport master (
    output stall, flush, valid_E, Branch_E, bCondCheck_E, setFlags_E,
           MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E,
           zero_E, negative_E, overflow_E, carry_E,
           aluResult_E, writeData_E, Rd_E,
    input  valid_M, Branch_M, bCondCheck_M, MemRead_M, MemWrite_M,
           RegWrite_M, MemtoReg_M, zero_M, zero_flag, negative, overflow,
           carry, aluResult_M, writeData_M, Rt_B_cond, nzcv_q
  );

  modport slave (
    input  stall, flush, valid_E, Branch_E, bCondCheck_E, setFlags_E,
           MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E,
           zero_E, negative_E, overflow_E, carry_E,
           aluResult_E, writeData_E, Rd_E,
    output valid_M, Branch_M, bCondCheck_M, MemRead_M, MemWrite_M,
           RegWrite_M, MemtoReg_M, zero_M, zero_flag, negative, overflow,
           carry, aluResult_M, writeData_M, Rt_B_cond, nzcv_q
  );
endinterface

// File: rtl/ex_mem_flags_stage.sv
// EX/MEM pipeline register that also owns the architectural NZCV flags, so a
// B.cond reaching MEM sees the flags of the youngest older flag setter.
module ex_mem_flags_stage #(
  parameter int N = 64
) (
  input logic                  clk,
  input logic                  reset,
  ex_mem_flags_stage_if.slave  bus
);

  // {valid, Branch, bCondCheck, MemRead, MemWrite, RegWrite, MemtoReg}
  logic [6:0]   ctrl_q;
  logic         zero_q;
  logic [3:0]   pres_q;
  logic [3:0]   nzcv_r;
  logic [N-1:0] alu_q;
  logic [N-1:0] wdata_q;
  logic [4:0]   rt_q;

  logic         flag_upd;
  logic [3:0]   eff_flags;

  // Flag order everywhere is {N, Z, C, V}.
  always_comb begin
    flag_upd  = bus.valid_E & bus.setFlags_E;
    eff_flags = nzcv_r;
    if (flag_upd)
      eff_flags = {bus.negative_E, bus.zero_E, bus.carry_E, bus.overflow_E};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      zero_q  <= 1'b0;
      pres_q  <= '0;
      nzcv_r  <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      rt_q    <= '0;
    end else if (bus.flush) begin
      // Bubble: kill controls only; flags and data fields are don't-care.
      ctrl_q <= '0;
    end else if (!bus.stall) begin
      ctrl_q  <= bus.valid_E ? {1'b1, bus.Branch_E, bus.bCondCheck_E, bus.MemRead_E,
                                bus.MemWrite_E, bus.RegWrite_E, bus.MemtoReg_E}
                             : 7'b0;
      zero_q  <= bus.zero_E;
      pres_q  <= eff_flags;
      nzcv_r  <= eff_flags;
      alu_q   <= bus.aluResult_E;
      wdata_q <= bus.writeData_E;
      rt_q    <= bus.Rd_E;
    end
  end

  assign bus.valid_M      = ctrl_q[6];
  assign bus.Branch_M     = ctrl_q[5];
  assign bus.bCondCheck_M = ctrl_q[4];
  assign bus.MemRead_M    = ctrl_q[3];
  assign bus.MemWrite_M   = ctrl_q[2];
  assign bus.RegWrite_M   = ctrl_q[1];
  assign bus.MemtoReg_M   = ctrl_q[0];
  assign bus.zero_M       = zero_q;
  assign bus.negative     = pres_q[3];
  assign bus.zero_flag    = pres_q[2];
  assign bus.carry        = pres_q[1];
  assign bus.overflow     = pres_q[0];
  assign bus.aluResult_M  = alu_q;
  assign bus.writeData_M  = wdata_q;
  assign bus.Rt_B_cond    = rt_q;
  assign bus.nzcv_q       = nzcv_r;

endmodule

// File: tb/tb_ex_mem_flags_stage.sv
// Self-checking bench for ex_mem_flags_stage: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_ex_mem_flags_stage;
  localparam int N = 64;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ex_mem_flags_stage_if #(.N(N)) bus ();

  ex_mem_flags_stage #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] ctrl_m;
  logic [4:0] flg_m;
  assign ctrl_m = {bus.valid_M, bus.Branch_M, bus.bCondCheck_M, bus.MemRead_M,
                   bus.MemWrite_M, bus.RegWrite_M, bus.MemtoReg_M};
  assign flg_m  = {bus.zero_M, bus.negative, bus.zero_flag, bus.carry, bus.overflow};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.stall = 0; bus.flush = 0; bus.valid_E = 0; bus.Branch_E = 0;
    bus.bCondCheck_E = 0; bus.setFlags_E = 0; bus.MemRead_E = 0; bus.MemWrite_E = 0;
    bus.RegWrite_E = 0; bus.MemtoReg_E = 0; bus.zero_E = 0; bus.negative_E = 0;
    bus.overflow_E = 0; bus.carry_E = 0; bus.aluResult_E = '0; bus.writeData_E = '0;
    bus.Rd_E = '0;
  endtask

  task automatic rand_ex();
    bus.valid_E = 1'($urandom); bus.Branch_E = 1'($urandom);
    bus.bCondCheck_E = 1'($urandom); bus.setFlags_E = 1'($urandom);
    bus.MemRead_E = 1'($urandom); bus.MemWrite_E = 1'($urandom);
    bus.RegWrite_E = 1'($urandom); bus.MemtoReg_E = 1'($urandom);
    bus.zero_E = 1'($urandom); bus.negative_E = 1'($urandom);
    bus.overflow_E = 1'($urandom); bus.carry_E = 1'($urandom);
    bus.aluResult_E = {$urandom, $urandom}; bus.writeData_E = {$urandom, $urandom};
    bus.Rd_E = 5'($urandom);
  endtask

  task automatic test_reset();
    reset = 1; rand_ex(); bus.stall = 1; bus.flush = 0;
    tick();
    checks++;
    if ({ctrl_m, flg_m, bus.Rt_B_cond, bus.nzcv_q} !== '0 ||
        bus.aluResult_M !== '0 || bus.writeData_M !== '0) begin
      errors++;
      $display("FAIL reset_edge1 ctrl=%b flg=%b rt=%h nzcv=%b alu=%h wd=%h required all 0",
               ctrl_m, flg_m, bus.Rt_B_cond, bus.nzcv_q, bus.aluResult_M, bus.writeData_M);
    end
    rand_ex();
    tick();
    checks++;
    if ({ctrl_m, flg_m, bus.Rt_B_cond, bus.nzcv_q} !== '0 ||
        bus.aluResult_M !== '0 || bus.writeData_M !== '0) begin
      errors++;
      $display("FAIL reset_edge2 ctrl=%b flg=%b rt=%h nzcv=%b required all 0",
               ctrl_m, flg_m, bus.Rt_B_cond, bus.nzcv_q);
    end
    reset = 0; set_idle();
  endtask

  task automatic test_subs_bcond();
    set_idle();
    bus.valid_E = 1; bus.setFlags_E = 1; bus.RegWrite_E = 1;
    bus.negative_E = 1; bus.zero_E = 0; bus.carry_E = 0; bus.overflow_E = 1; bus.Rd_E = 5'd3;
    tick();
    checks++;
    if (bus.nzcv_q !== 4'b1001) begin
      errors++; $display("FAIL subs_nzcv got=%b required=1001", bus.nzcv_q);
    end
    set_idle();
    bus.valid_E = 1; bus.bCondCheck_E = 1; bus.Rd_E = 5'b01011;
    bus.negative_E = 0; bus.zero_E = 1; bus.carry_E = 1; bus.overflow_E = 0;
    tick();
    checks++;
    if ({bus.bCondCheck_M, bus.Rt_B_cond} !== {1'b1, 5'b01011}) begin
      errors++;
      $display("FAIL bcond_ctrl bc=%b rt=%b required bc=1 rt=01011", bus.bCondCheck_M, bus.Rt_B_cond);
    end
    checks++;
    if ({bus.negative, bus.zero_flag, bus.carry, bus.overflow} !== 4'b1001) begin
      errors++;
      $display("FAIL bcond_flags nzcv_pres=%b required=1001",
               {bus.negative, bus.zero_flag, bus.carry, bus.overflow});
    end
    set_idle();
  endtask

  task automatic test_add_noflags();
    set_idle();
    bus.valid_E = 1; bus.setFlags_E = 1;
    bus.negative_E = 0; bus.zero_E = 1; bus.carry_E = 1; bus.overflow_E = 0;
    tick();
    set_idle();
    bus.valid_E = 1; bus.RegWrite_E = 1; bus.zero_E = 1;
    bus.negative_E = 1; bus.carry_E = 0; bus.overflow_E = 1;
    tick();
    checks++;
    if (flg_m !== 5'b1_0110) begin
      errors++; $display("FAIL add_zero_flags got=%b required=10110", flg_m);
    end
    checks++;
    if (bus.nzcv_q !== 4'b0110) begin
      errors++; $display("FAIL add_nzcv_hold got=%b required=0110", bus.nzcv_q);
    end
    set_idle();
  endtask

  task automatic test_flush();
    set_idle();
    bus.flush = 1; bus.valid_E = 1; bus.setFlags_E = 1; bus.MemWrite_E = 1;
    bus.negative_E = 1; bus.zero_E = 1; bus.carry_E = 1; bus.overflow_E = 1;
    tick();
    checks++;
    if ({bus.valid_M, bus.MemWrite_M, bus.nzcv_q} !== {2'b00, 4'b0110}) begin
      errors++;
      $display("FAIL flush_bubble valid=%b mw=%b nzcv=%b required 0 0 0110",
               bus.valid_M, bus.MemWrite_M, bus.nzcv_q);
    end
    set_idle();
  endtask

  task automatic test_stall();
    logic [N-1:0] s_alu, s_wd;
    logic [4:0]   s_rt;
    logic [3:0]   s_f;
    set_idle();
    rand_ex();
    bus.valid_E = 1; bus.setFlags_E = 1; bus.MemtoReg_E = 1;
    s_alu = bus.aluResult_E; s_wd = bus.writeData_E; s_rt = bus.Rd_E;
    s_f = {bus.negative_E, bus.zero_E, bus.carry_E, bus.overflow_E};
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      bus.stall = 1;
      tick();
      checks++;
      if (bus.aluResult_M !== s_alu || bus.writeData_M !== s_wd || bus.Rt_B_cond !== s_rt ||
          bus.nzcv_q !== s_f || flg_m[3:0] !== s_f || flg_m[4] !== s_f[2] ||
          bus.valid_M !== 1'b1 || bus.MemtoReg_M !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d alu=%h wd=%h rt=%h nzcv=%b flg=%b required alu=%h wd=%h rt=%h nzcv=%b",
                 i, bus.aluResult_M, bus.writeData_M, bus.Rt_B_cond, bus.nzcv_q, flg_m,
                 s_alu, s_wd, s_rt, s_f);
      end
    end
    rand_ex();
    bus.stall = 0; bus.valid_E = 1; bus.setFlags_E = 0;
    tick();
    checks++;
    if (bus.aluResult_M !== bus.aluResult_E || bus.writeData_M !== bus.writeData_E ||
        bus.Rt_B_cond !== bus.Rd_E || bus.nzcv_q !== s_f || flg_m !== {bus.zero_E, s_f} ||
        ctrl_m !== {1'b1, bus.Branch_E, bus.bCondCheck_E, bus.MemRead_E, bus.MemWrite_E,
                    bus.RegWrite_E, bus.MemtoReg_E}) begin
      errors++;
      $display("FAIL stall_release alu=%h rt=%h ctrl=%b flg=%b nzcv=%b required alu=%h rt=%h nzcv=%b",
               bus.aluResult_M, bus.Rt_B_cond, ctrl_m, flg_m, bus.nzcv_q,
               bus.aluResult_E, bus.Rd_E, s_f);
    end
    set_idle();
  endtask

  task automatic test_stall_flush_reset();
    set_idle();
    bus.valid_E = 1; bus.RegWrite_E = 1; tick();
    bus.stall = 1; bus.flush = 1; bus.valid_E = 1; bus.MemWrite_E = 1; bus.RegWrite_E = 0;
    tick();
    checks++;
    if (ctrl_m[6:1] !== 6'b0) begin
      errors++; $display("FAIL stall_flush_bubble ctrl=%b required 000000x", ctrl_m);
    end
    rand_ex(); bus.flush = 1; bus.stall = 1; reset = 1;
    tick();
    checks++;
    if ({ctrl_m, flg_m, bus.Rt_B_cond, bus.nzcv_q} !== '0 ||
        bus.aluResult_M !== '0 || bus.writeData_M !== '0) begin
      errors++;
      $display("FAIL reset_with_flush ctrl=%b flg=%b rt=%h nzcv=%b required all 0",
               ctrl_m, flg_m, bus.Rt_B_cond, bus.nzcv_q);
    end
    reset = 0; set_idle();
  endtask

  // Behavioural model: tracks what the stage must show, and which fields are
  // don't-care after a bubble.
  task automatic test_random();
    logic [6:0]   e_ctrl;
    logic         e_m2r_known, e_data_known;
    logic [4:0]   e_flg;
    logic [3:0]   e_nzcv, fx;
    logic [N-1:0] e_alu, e_wd;
    logic [4:0]   e_rt;
    e_ctrl = '0; e_m2r_known = 1; e_data_known = 1; e_flg = '0; e_nzcv = '0;
    e_alu = '0; e_wd = '0; e_rt = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rand_ex();
      reset     = (cyc == 0) || ($urandom_range(99) < 3);
      bus.flush = ($urandom_range(99) < 15);
      bus.stall = ($urandom_range(99) < 25);
      if (reset) begin
        e_ctrl = '0; e_m2r_known = 1; e_data_known = 1; e_flg = '0; e_nzcv = '0;
        e_alu = '0; e_wd = '0; e_rt = '0;
      end else if (bus.flush) begin
        e_ctrl = '0; e_m2r_known = 0; e_data_known = 0;
      end else if (!bus.stall) begin
        if (bus.valid_E) begin
          e_ctrl = {1'b1, bus.Branch_E, bus.bCondCheck_E, bus.MemRead_E, bus.MemWrite_E,
                    bus.RegWrite_E, bus.MemtoReg_E};
          e_m2r_known = 1;
          if (bus.setFlags_E)
            e_nzcv = {bus.negative_E, bus.zero_E, bus.carry_E, bus.overflow_E};
        end else begin
          e_ctrl = '0; e_m2r_known = 0;
        end
        fx = e_nzcv;
        e_flg = {bus.zero_E, fx};
        e_alu = bus.aluResult_E; e_wd = bus.writeData_E; e_rt = bus.Rd_E;
        e_data_known = 1;
      end
      tick();
      checks++;
      if (ctrl_m[6:1] !== e_ctrl[6:1] || (e_m2r_known && ctrl_m[0] !== e_ctrl[0])) begin
        errors++; $display("FAIL rand_ctrl cyc=%0d got=%b required=%b", cyc, ctrl_m, e_ctrl);
      end
      checks++;
      if (bus.nzcv_q !== e_nzcv) begin
        errors++; $display("FAIL rand_nzcv cyc=%0d got=%b required=%b", cyc, bus.nzcv_q, e_nzcv);
      end
      if (e_data_known) begin
        checks++;
        if (flg_m !== e_flg || bus.aluResult_M !== e_alu || bus.writeData_M !== e_wd ||
            bus.Rt_B_cond !== e_rt) begin
          errors++;
          $display("FAIL rand_data cyc=%0d flg=%b alu=%h wd=%h rt=%h required flg=%b alu=%h wd=%h rt=%h",
                   cyc, flg_m, bus.aluResult_M, bus.writeData_M, bus.Rt_B_cond,
                   e_flg, e_alu, e_wd, e_rt);
        end
      end
    end
    reset = 0; set_idle();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1; set_idle();
    #2;
    test_reset();
    test_subs_bcond();
    test_add_noflags();
    test_flush();
    test_stall();
    test_stall_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
